stage_profiler: RTL
===================

Name: stage_profiler

Overview:
- Downstream consumer of the per-stage valid pulses (spmm, dmvm, sm, aggr) and of the three 32-bit debug words produced by the debug monitor.
- Profiles one accelerator run between start and stop or timeout: total cycles, first-valid latency per stage, and valid-pulse count per stage.
- Snapshots the debug words at end of run.
- Exposes all results through a fixed-latency register read port to the host/ILA side.

Parameters:
- CNT_W, 32, width of every counter and read-data word.
- TIMEOUT, 32'd1_000_000, RUN cycles before forced termination; must be >= 1.
- ADDR_W, 4, read-address width (16-entry map).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse; clear all results and begin a run.
- stop_i  in  1  pulse; end the run.
- stage_vld_i  in  4  stage valids: [0] spmm, [1] dmvm, [2] sm, [3] aggr.
- debug_1_i / debug_2_i / debug_3_i  in  32 each  debug words, sampled at end of run.
- rd_req_i  in  1  read request.
- rd_addr_i  in  ADDR_W  read address.
- rd_vld_o  out  1  read data valid.
- rd_data_o  out  CNT_W  read data.
- busy_o  out  1  FSM in RUN.
- done_o  out  1  FSM in DONE.

Behaviour:
- Reset values (rst asserted, asynchronous): FSM IDLE, all counters 0, first-latency registers all-ones, seen mask 0, timeout flag 0, snapshots 0, rd_vld_o 0, rd_data_o 0, busy_o 0, done_o 0.
- Reset asserted mid-run aborts the run immediately; no partial results are retained.
- FSM states are IDLE, RUN and DONE. busy_o is high only in RUN; done_o is high only in DONE.
- Transitions:
  - IDLE -> RUN on start_i.
  - RUN -> DONE on stop_i, or on the cycle where cyc_cnt == TIMEOUT-1.
  - RUN -> RUN on start_i: restart, results cleared.
  - DONE -> RUN on start_i.
  - start_i and stop_i in the same cycle: start wins.
- start_i cycle: clear cyc_cnt, vld_cnt[*], seen and timeout; set first_lat[*] to all-ones. stage_vld_i in the start_i cycle is ignored.
- RUN cycle accounting:
  - cyc_cnt holds 0 in the first RUN cycle and increments at the end of every RUN cycle, including the stop or timeout cycle.
  - Saturates at all-ones.
- Per stage s, in a RUN cycle with stage_vld_i[s]=1:
  - vld_cnt[s]++ (saturating); a multi-cycle high counts once per cycle.
  - If seen[s]==0: first_lat[s] <= cyc_cnt and seen[s] <= 1.
- Stop/timeout cycle: stage valids are still counted. debug_1..3 are registered into snap_1..3 on the same edge that enters DONE.
- Timeout: timeout flag is set on entering DONE via timeout; cyc_cnt then reads TIMEOUT. If stop_i and timeout coincide, the timeout flag is still set.
- Register map (word addresses):
  - 0: status {CNT_W-7 zeros, timeout, seen[3:0], busy, done} — done at bit 0, busy at bit 1, seen[3:0] at bits 5:2, timeout at bit 6.
  - 1: cyc_cnt.
  - 2–5: first_lat[0..3].
  - 6–9: vld_cnt[0..3].
  - 10–12: snap_1..3.
  - 13–15: 0.
- Read port:
  - No backpressure; one request per cycle accepted.
  - rd_vld_o equals rd_req_i delayed by one cycle.
  - rd_data_o is the value in the registered map at the request edge, i.e. pre-update values for a read in the same cycle as a counter update.
  - rd_data_o holds its last value while rd_vld_o is low.
  - Reads are legal in every state; RUN reads return live values.

Decomposition:
- Shared package (gat_dbg_pkg):
  - enum prof_state_e {IDLE, RUN, DONE}.
  - Stage index constants STG_SPMM=0, STG_DMVM=1, STG_SM=2, STG_AGGR=3, NUM_STAGES=4.
  - Register address constants ADDR_STATUS..ADDR_SNAP3.
- Sub-module stage_counter, instantiated once per stage: owns seen, first_lat and vld_cnt; inputs are clear, run, vld and cyc_cnt.
- FSM, cycle counter, snapshot registers and read mux stay in the top.

Test Plan:
- Reset then reads:
  - rd addr 0 -> rd_data_o 0 one cycle after the request.
  - addr 2 -> 32'hFFFF_FFFF.
  - addr 13 -> 0.
- start_i at T:
  - stage_vld_i[0] at T+3, T+4, T+10; stop_i at T+20.
  - Expect first_lat[0]=2, vld_cnt[0]=3, cyc_cnt=20, status=0x05 (done, seen[0]).
- Timeout with TIMEOUT=16, no stop_i:
  - done_o rises at T+17; cyc_cnt=16; status bit 6 set.
  - first_lat[1]=all-ones when stage 1 is never pulsed.
- Restart in RUN:
  - stage_vld_i[3] at T+2; start_i again at T+5 with stage_vld_i[3]=1 in that cycle.
  - Expect vld_cnt[3]=0 and seen[3]=0 after the restart.
- Snapshot: debug_2_i=0xA5 on the stop cycle, changed to 0x3C afterwards -> addr 11 reads 0xA5.
- Async reset mid-RUN at T+7:
  - busy_o drops without waiting for a clk edge.
  - All reads return reset values.
  - A new start_i runs normally.

Source files
------------

// File: rtl/gat_dbg_pkg.sv
// Shared types and constants for the stage profiler: FSM states,
// stage indices and the word addresses of the profiler register map.
package gat_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } prof_state_e;

    localparam int STG_SPMM   = 0;
    localparam int STG_DMVM   = 1;
    localparam int STG_SM     = 2;
    localparam int STG_AGGR   = 3;
    localparam int NUM_STAGES = 4;

    localparam int ADDR_STATUS = 0;
    localparam int ADDR_CYC    = 1;
    localparam int ADDR_LAT0   = 2;
    localparam int ADDR_LAT1   = 3;
    localparam int ADDR_LAT2   = 4;
    localparam int ADDR_LAT3   = 5;
    localparam int ADDR_VLD0   = 6;
    localparam int ADDR_VLD1   = 7;
    localparam int ADDR_VLD2   = 8;
    localparam int ADDR_VLD3   = 9;
    localparam int ADDR_SNAP1  = 10;
    localparam int ADDR_SNAP2  = 11;
    localparam int ADDR_SNAP3  = 12;

endpackage

// File: rtl/stage_counter.sv
// Per-stage profiling counters: first-valid latency and valid-pulse count.
// Ports:
//   clk, rst       clock, async active-high reset
//   clear_i        start of a new run; wipes this stage's results
//   run_i          profiler is in RUN this cycle
//   vld_i          stage valid pulse
//   cyc_cnt_i      current run cycle number
//   seen_o         stage has produced at least one valid this run
//   first_lat_o    cycle number of the first valid (all-ones if none)
//   vld_cnt_o      number of valid cycles this run (saturating)
module stage_counter
    import gat_dbg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic             vld_i,
    input  logic [CNT_W-1:0] cyc_cnt_i,
    output logic             seen_o,
    output logic [CNT_W-1:0] first_lat_o,
    output logic [CNT_W-1:0] vld_cnt_o
);

    logic             seen_q, seen_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority so valids in the start cycle are dropped.
    always_comb begin
        seen_d = seen_q;
        lat_d  = lat_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            seen_d = 1'b0;
            lat_d  = '1;
            cnt_d  = '0;
        end else if (run_i && vld_i) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (!seen_q) begin
                seen_d = 1'b1;
                lat_d  = cyc_cnt_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 1'b0;
            lat_q  <= '1;
            cnt_q  <= '0;
        end else begin
            seen_q <= seen_d;
            lat_q  <= lat_d;
            cnt_q  <= cnt_d;
        end
    end

    assign seen_o      = seen_q;
    assign first_lat_o = lat_q;
    assign vld_cnt_o   = cnt_q;

endmodule

// File: rtl/stage_profiler.sv
// Profiles one accelerator run: cycle count, per-stage first-valid
// latency and valid count, debug-word snapshot, host read port.
// Ports:
//   clk, rst                  clock, async active-high reset
//   start_i / stop_i          run control pulses (start wins)
//   stage_vld_i[3:0]          spmm, dmvm, sm, aggr valids
//   debug_1_i..debug_3_i      debug words captured at end of run
//   rd_req_i, rd_addr_i       register read request
//   rd_vld_o, rd_data_o       read response, one cycle later
//   busy_o / done_o           FSM in RUN / DONE
module stage_profiler
    import gat_dbg_pkg::*;
#(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] TIMEOUT = 32'd1_000_000,
    parameter int               ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [NUM_STAGES-1:0] stage_vld_i,
    input  logic [31:0]           debug_1_i,
    input  logic [31:0]           debug_2_i,
    input  logic [31:0]           debug_3_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic                  rd_vld_o,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [CNT_W-1:0] LIMIT = TIMEOUT - 1'b1;

    prof_state_e      state_q;
    logic             busy_q, done_q;
    logic             tmo_q;
    logic [CNT_W-1:0] cyc_q;
    logic [31:0]      snap1_q, snap2_q, snap3_q;
    logic             rd_vld_q;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_word;
    logic             at_limit;

    logic [NUM_STAGES-1:0] seen;
    logic [CNT_W-1:0]      lat [NUM_STAGES];
    logic [CNT_W-1:0]      cnt [NUM_STAGES];

    assign at_limit = (cyc_q == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cyc_q   <= '0;
            snap1_q <= '0;
            snap2_q <= '0;
            snap3_q <= '0;
        end else if (start_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    // The stop/timeout cycle is itself counted.
                    if (cyc_q != '1) begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                    if (stop_i || at_limit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tmo_q   <= at_limit;
                        snap1_q <= debug_1_i;
                        snap2_q <= debug_2_i;
                        snap3_q <= debug_3_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        stage_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .clear_i     (start_i),
            .run_i       (busy_q),
            .vld_i       (stage_vld_i[s]),
            .cyc_cnt_i   (cyc_q),
            .seen_o      (seen[s]),
            .first_lat_o (lat[s]),
            .vld_cnt_o   (cnt[s])
        );
    end

    always_comb begin
        rd_word = '0;
        unique case (rd_addr_i)
            ADDR_W'(ADDR_STATUS):
                rd_word = {{(CNT_W-7){1'b0}},
                           tmo_q, seen, busy_q, done_q};
            ADDR_W'(ADDR_CYC):   rd_word = cyc_q;
            ADDR_W'(ADDR_LAT0):  rd_word = lat[STG_SPMM];
            ADDR_W'(ADDR_LAT1):  rd_word = lat[STG_DMVM];
            ADDR_W'(ADDR_LAT2):  rd_word = lat[STG_SM];
            ADDR_W'(ADDR_LAT3):  rd_word = lat[STG_AGGR];
            ADDR_W'(ADDR_VLD0):  rd_word = cnt[STG_SPMM];
            ADDR_W'(ADDR_VLD1):  rd_word = cnt[STG_DMVM];
            ADDR_W'(ADDR_VLD2):  rd_word = cnt[STG_SM];
            ADDR_W'(ADDR_VLD3):  rd_word = cnt[STG_AGGR];
            ADDR_W'(ADDR_SNAP1): rd_word = CNT_W'(snap1_q);
            ADDR_W'(ADDR_SNAP2): rd_word = CNT_W'(snap2_q);
            ADDR_W'(ADDR_SNAP3): rd_word = CNT_W'(snap3_q);
            default:             rd_word = '0;
        endcase
    end

    // Data is held between requests so an ILA sees a stable word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign rd_vld_o  = rd_vld_q;
    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
